// File: rtl/bench_stim_ctl.sv
// bench_stim_ctl: self-test driver for ISCAS89-style sequential benchmarks.
// An LFSR generates input vectors for the benchmark. The benchmark's output
// bit is compacted into a MISR signature, which is compared with a golden
// value at the end of the run.
module bench_stim_ctl #(
    parameter int unsigned NUM_VEC     = 1024,     // vectors per run, 1..65535
    parameter logic [15:0] SEED        = 16'hACE1, // 0 is replaced by 16'h0001
    parameter int unsigned DUT_RST_CYC = 2         // benchmark reset cycles, 1..15
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active low
    input  logic        start,
    input  logic [15:0] golden_sig,
    input  logic        dut_out,
    output logic [15:0] dut_in,
    output logic        dut_reset_n,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VEC - 1);
    localparam logic [3:0]  LAST_RST = 4'(DUT_RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Shared feedback polynomial: taps 16, 14, 13, 11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic s);
        return lfsr_step(m) ^ {15'b0, s};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] misr_next;
    logic        sample_en;

    logic [15:0] dut_in_q, dut_in_d;
    logic        dut_rst_n_q, dut_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] sig_q, sig_d;

    // Sequencing: state, counters, LFSR, MISR and the result registers.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        vec_cnt_d = vec_cnt_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        pass_d    = pass_q;
        sig_d     = sig_q;
        sample_en = 1'b0;
        misr_next = misr_step(misr_q, dut_out);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DUT_RST;
                    rst_cnt_d = '0;
                    vec_cnt_d = '0;
                    lfsr_d    = SEED_EFF;
                    misr_d    = '0;
                    pass_d    = 1'b0;
                end
            end
            S_DUT_RST: begin
                if (rst_cnt_q == LAST_RST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                // The benchmark output lags its input by one cycle, so the
                // first RUN cycle has no response yet.
                sample_en = (vec_cnt_q != 16'd0);
                if (vec_cnt_q == LAST_VEC) begin
                    state_d = S_DRAIN;
                end else begin
                    vec_cnt_d = vec_cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                // Response to the final vector arrives here.
                sample_en = 1'b1;
                state_d   = S_DONE;
                sig_d     = misr_next;
                pass_d    = (misr_next == golden_sig);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample_en) begin
            misr_d = misr_next;
        end

        // The vector for the upcoming RUN cycle is taken from the LFSR, which
        // then advances; entering RUN from DUT_RST therefore emits the seed.
        if (state_d == S_RUN) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        dut_in_d    = '0;
        dut_rst_n_d = (state_d != S_DUT_RST);
        busy_d      = (state_d == S_DUT_RST) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        if (state_d == S_RUN) begin
            dut_in_d = lfsr_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            vec_cnt_q <= '0;
            lfsr_q    <= SEED_EFF;
            misr_q    <= '0;
            pass_q    <= 1'b0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            vec_cnt_q <= vec_cnt_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            pass_q    <= pass_d;
            sig_q     <= sig_d;
        end
    end

    // Output registers; the benchmark is held in reset while we are.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dut_in_q    <= '0;
            dut_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            dut_in_q    <= dut_in_d;
            dut_rst_n_q <= dut_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dut_in      = dut_in_q;
    assign dut_reset_n = dut_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign signature   = sig_q;

endmodule

// File: tb/tb_bench_stim_ctl.sv
// Testbench for bench_stim_ctl: three configurations checked every cycle
// against a timeline-based reference model, plus literal checks.
module tb_bench_stim_ctl;

    localparam int NI = 3;
    localparam int NVA [NI] = '{4, 4, 21};
    localparam int RCA [NI] = '{2, 2, 3};
    localparam logic [15:0] SDA [NI] = '{16'h0001, 16'h0000, 16'hACE1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [15:0] golden;

    logic [15:0] o_din [NI];
    logic [15:0] o_sig [NI];
    logic        o_rn [NI];
    logic        o_busy [NI];
    logic        o_done [NI];
    logic        o_pass [NI];
    logic        dout_w [NI];

    bit   [15:0] acc [NI];
    bit   [1:0]  mode [NI];   // 0: XOR accumulator, 1: tied 0, 2: random
    bit          rbit [NI];

    int total = 0;
    int bad   = 0;

    bench_stim_ctl #(.NUM_VEC(4), .SEED(16'h0001), .DUT_RST_CYC(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .golden_sig(golden), .dut_out(dout_w[0]),
        .dut_in(o_din[0]), .dut_reset_n(o_rn[0]), .busy(o_busy[0]), .done(o_done[0]),
        .pass(o_pass[0]), .signature(o_sig[0]));

    bench_stim_ctl #(.NUM_VEC(4), .SEED(16'h0000), .DUT_RST_CYC(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .golden_sig(golden), .dut_out(dout_w[1]),
        .dut_in(o_din[1]), .dut_reset_n(o_rn[1]), .busy(o_busy[1]), .done(o_done[1]),
        .pass(o_pass[1]), .signature(o_sig[1]));

    bench_stim_ctl #(.NUM_VEC(21), .SEED(16'hACE1), .DUT_RST_CYC(3)) u2 (
        .clk(clk), .reset(reset), .start(start), .golden_sig(golden), .dut_out(dout_w[2]),
        .dut_in(o_din[2]), .dut_reset_n(o_rn[2]), .busy(o_busy[2]), .done(o_done[2]),
        .pass(o_pass[2]), .signature(o_sig[2]));

    // Benchmark stand-in: registered XOR accumulator, out = state[0].
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            acc[i] <= o_rn[i] ? (acc[i] ^ o_din[i]) : 16'h0000;
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dout_w[i] = (mode[i] == 2'd0) ? acc[i][0] : (mode[i] == 2'd1) ? 1'b0 : rbit[i];
        end
    end

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] vec_k(input logic [15:0] seed, input int k);
        logic [15:0] v;
        v = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int j = 0; j < k; j++) v = nxt(v);
        return v;
    endfunction

    function automatic logic [15:0] misr_nxt(input logic [15:0] m, input logic s);
        return nxt(m) ^ {15'b0, s};
    endfunction

    // Reference model: m_c counts edges since the accepted start edge.
    // c < R: benchmark reset; R..R+N-1: RUN; R+N: DRAIN; R+N+1: DONE.
    // Samples land on edges R+2..R+N and R+N+1.
    bit          m_act [NI];
    int          m_c [NI];
    bit          m_rn [NI];
    logic [15:0] m_misr [NI];
    logic [15:0] m_sig [NI];
    bit          m_pass [NI];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                m_act[i]  <= 1'b0;
                m_c[i]    <= 0;
                m_rn[i]   <= 1'b0;
                m_misr[i] <= 16'h0000;
                m_sig[i]  <= 16'h0000;
                m_pass[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_rn[i] <= 1'b1;
                if (m_act[i]) begin
                    m_c[i] <= m_c[i] + 1;
                    if (m_c[i] + 1 >= RCA[i] + 2 && m_c[i] + 1 <= RCA[i] + NVA[i]) begin
                        m_misr[i] <= misr_nxt(m_misr[i], dout_w[i]);
                    end else if (m_c[i] + 1 == RCA[i] + NVA[i] + 1) begin
                        m_misr[i] <= misr_nxt(m_misr[i], dout_w[i]);
                        m_sig[i]  <= misr_nxt(m_misr[i], dout_w[i]);
                        m_pass[i] <= (misr_nxt(m_misr[i], dout_w[i]) == golden);
                    end else if (m_c[i] + 1 >= RCA[i] + NVA[i] + 2) begin
                        m_act[i] <= 1'b0;
                    end
                end else if (start) begin
                    m_act[i]  <= 1'b1;
                    m_c[i]    <= 0;
                    m_misr[i] <= 16'h0000;
                    m_pass[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, compare every instance against
    // the model, then refresh the random response bits.
    task automatic step();
        int r;
        int n;
        logic [15:0] ed;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            r = RCA[i];
            n = NVA[i];
            ed = (m_act[i] && m_c[i] >= r && m_c[i] <= r + n - 1) ? vec_k(SDA[i], m_c[i] - r) : 16'h0000;
            chk($sformatf("u%0d.dut_in", i), o_din[i], ed);
            chk($sformatf("u%0d.dut_reset_n", i), 16'(o_rn[i]), 16'(m_rn[i] && !(m_act[i] && m_c[i] < r)));
            chk($sformatf("u%0d.busy", i), 16'(o_busy[i]), 16'(m_act[i] && m_c[i] <= r + n));
            chk($sformatf("u%0d.done", i), 16'(o_done[i]), 16'(m_act[i] && m_c[i] == r + n + 1));
            chk($sformatf("u%0d.pass", i), 16'(o_pass[i]), 16'(m_pass[i]));
            chk($sformatf("u%0d.signature", i), o_sig[i], m_sig[i]);
        end
        for (int i = 0; i < NI; i++) rbit[i] = 1'($urandom_range(0, 1));
    endtask

    logic [15:0] gseq [4];
    int          first_done;
    int          ndone;

    initial begin
        gseq[0] = 16'h0001; gseq[1] = 16'h0002; gseq[2] = 16'h0004; gseq[3] = 16'h0008;
        reset  = 1'b0;
        start  = 1'b0;
        golden = 16'h000F;
        for (int i = 0; i < NI; i++) mode[i] = 2'd0;

        // Reset values
        repeat (3) step();
        chk("rst.dut_reset_n", 16'(o_rn[0]), 16'h0000);
        chk("rst.signature", o_sig[0], 16'h0000);
        #2 reset = 1'b1;
        step();
        chk("rel.dut_reset_n", 16'(o_rn[0]), 16'h0001);
        chk("rel.busy", 16'(o_busy[0]), 16'h0000);

        // Golden run (u1 is the zero-seed variant)
        start = 1'b1;
        first_done = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) start = 1'b0;
            if (n >= 3 && n <= 6) begin
                chk("gold.u0.vec", o_din[0], gseq[n - 3]);
                chk("zseed.u1.vec", o_din[1], gseq[n - 3]);
            end
            if (o_done[0] && first_done == 0) first_done = n;
        end
        chk("gold.done_cycle", 16'(first_done), 16'd8);
        chk("gold.signature", o_sig[0], 16'h000F);
        chk("gold.pass", 16'(o_pass[0]), 16'h0001);
        chk("zseed.signature", o_sig[1], 16'h000F);
        chk("zseed.pass", 16'(o_pass[1]), 16'h0001);

        // Mismatch: response tied low
        mode[0] = 2'd1;
        mode[1] = 2'd1;
        start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) start = 1'b0;
            if (o_done[0]) ndone++;
        end
        chk("mism.done_count", 16'(ndone), 16'd1);
        chk("mism.signature", o_sig[0], 16'h0000);
        chk("mism.pass", 16'(o_pass[0]), 16'h0000);

        // Ignored start during RUN and DONE
        mode[0] = 2'd0;
        mode[1] = 2'd0;
        start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            start = (n == 4 || n == 8);
            if (o_done[0]) ndone++;
        end
        chk("ign.done_count", 16'(ndone), 16'd1);
        chk("ign.busy_idle", 16'(o_busy[0]), 16'h0000);

        // Mid-run reset in RUN cycle 2, then a clean rerun
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        chk("abort.dut_in", o_din[0], 16'h0000);
        chk("abort.dut_reset_n", 16'(o_rn[0]), 16'h0000);
        chk("abort.busy", 16'(o_busy[0]), 16'h0000);
        chk("abort.done", 16'(o_done[0]), 16'h0000);
        chk("abort.pass", 16'(o_pass[0]), 16'h0000);
        chk("abort.signature", o_sig[0], 16'h0000);
        step();
        step();
        #2 reset = 1'b1;
        step();
        start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) start = 1'b0;
            if (o_done[0]) ndone++;
        end
        chk("rerun.done_count", 16'(ndone), 16'd1);
        chk("rerun.signature", o_sig[0], 16'h000F);
        chk("rerun.pass", 16'(o_pass[0]), 16'h0001);

        // Randomized responses, starts, goldens and occasional resets
        for (int i = 0; i < NI; i++) mode[i] = 2'd2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            start = ((cyc / 300) % 3 == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) golden = misr_nxt(m_misr[2], dout_w[2]);
            else golden = 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                step();
                #2 reset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
